// File: rtl/usart_pkg.sv
// Shared UART definitions: default clocking, bit-period derivation and FSM state encodings.
package usart_pkg;

  localparam int unsigned DEF_SYS_CLK_FRE = 50_000_000;
  localparam int unsigned DEF_BPS         = 9_600;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } usart_state_e;

  function automatic int unsigned bps_cnt(input int unsigned sys_clk_fre,
                                          input int unsigned bps);
    return sys_clk_fre / bps;
  endfunction

endpackage

// File: rtl/usart_rx_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detect; flops reset to line idle (1).
module usart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic uart_rxd,
  output logic rxd_s,
  output logic rxd_fall
);

  logic rxd_meta;
  logic rxd_sync;
  logic rxd_prev;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign rxd_s    = rxd_sync;
  assign rxd_fall = rxd_prev & ~rxd_sync;

endmodule

// File: rtl/usart_rx.sv
// UART 8N1 receiver with one-cycle done/error strobes.
// Define USART_RX_PARITY_EN to add a parity bit between data and stop.
module usart_rx
  import usart_pkg::*;
#(
  parameter int unsigned SYS_CLK_FRE = DEF_SYS_CLK_FRE,
  parameter int unsigned BPS         = DEF_BPS,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int unsigned BPS_CNT  = bps_cnt(SYS_CLK_FRE, BPS);
  localparam int unsigned HALF_CNT = BPS_CNT / 2;
  localparam int unsigned CNT_W    = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;

  usart_state_e     state_q, state_d;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             rxd_s, rxd_fall;
  logic             sample, wrap;
  logic             done_d, ferr_d, perr_d;
  logic             par_bad;

  usart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .rxd_s     (rxd_s),
    .rxd_fall  (rxd_fall)
  );

  assign sample = (clk_cnt == CNT_W'(HALF_CNT - 1));
  assign wrap   = (clk_cnt == CNT_W'(BPS_CNT - 1));

`ifdef USART_RX_PARITY_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      par_bad <= 1'b0;
    else if (state_q == IDLE)
      par_bad <= 1'b0;
    else if (state_q == PARITY && sample)
      par_bad <= rxd_s ^ (^shift_reg) ^ PARITY_ODD[0];
  end
`else
  logic unused_parity_cfg;
  assign par_bad           = 1'b0;
  assign unused_parity_cfg = ^PARITY_ODD;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    case (state_q)
      IDLE:   if (rxd_fall) state_d = START;
      START: begin
        if (sample && rxd_s) state_d = IDLE;
        else if (wrap)       state_d = DATA;
      end
      DATA: begin
        if (wrap && bit_cnt == 3'd7) begin
`ifdef USART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (wrap) state_d = STOP;
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (sample) begin
          state_d = IDLE;
          if (!rxd_s)       ferr_d = 1'b1;
          else if (par_bad) perr_d = 1'b1;
          else              done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      uart_data  <= '0;
      uart_done  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      uart_done  <= done_d;
      frame_err  <= ferr_d;
      parity_err <= perr_d;
      if (state_q == IDLE || state_d == IDLE || wrap)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + 1'b1;
      if (state_q == START)
        bit_cnt <= '0;
      else if (state_q == DATA && wrap)
        bit_cnt <= bit_cnt + 1'b1;
      if (state_q == DATA && sample)
        shift_reg[bit_cnt] <= rxd_s;
      if (done_d)
        uart_data <= shift_reg;
    end
  end

  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx with a 16-clock bit period.
module tb_usart_rx;

  localparam int unsigned CLK_FRE = 1_600_000;
  localparam int unsigned BIT     = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_data;
  logic       uart_done, frame_err, parity_err, rx_busy;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] log_data [0:15];
  int log_n = 0;
  int d0, f0, p0, n0;

  usart_rx #(.SYS_CLK_FRE(CLK_FRE), .BPS(CLK_FRE / 16), .PARITY_ODD(0)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .uart_rxd   (uart_rxd),
    .uart_data  (uart_data),
    .uart_done  (uart_done),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (uart_done) begin
      done_cnt++;
      if (log_n < 16) log_data[log_n] = uart_data;
      log_n++;
    end
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input logic has_par, input logic p);
    uart_rxd = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      clks(BIT);
    end
    if (has_par) begin
      uart_rxd = p;
      clks(BIT);
    end
    uart_rxd = stop;
    clks(BIT);
    uart_rxd = 1'b1;
  endtask

  initial begin
    clks(3);
    check("rst_data", uart_data, 8'h00);
    check("rst_done", uart_done, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_busy", rx_busy, 0);
    sys_rst_n = 1'b1;
    clks(20);

    // 1: single frame
    d0 = done_cnt;
    send(8'h55, 1'b1, 1'b0, 1'b0);
    clks(4);
    check("t1_data", uart_data, 8'h55);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_ferr_cnt", ferr_cnt, 0);
    check("t1_busy", rx_busy, 0);
    clks(20);

    // 2: back-to-back frames
    d0 = done_cnt; n0 = log_n;
    send(8'hA3, 1'b1, 1'b0, 1'b0);
    send(8'h0F, 1'b1, 1'b0, 1'b0);
    clks(4);
    check("t2_done_cnt", done_cnt - d0, 2);
    check("t2_first", log_data[n0], 8'hA3);
    check("t2_second", log_data[n0 + 1], 8'h0F);
    clks(20);

    // 3: 4-clock glitch
    d0 = done_cnt; f0 = ferr_cnt;
    uart_rxd = 1'b0;
    clks(4);
    uart_rxd = 1'b1;
    clks(1);
    check("t3_busy_hi", rx_busy, 1);
    clks(24);
    check("t3_busy_lo", rx_busy, 0);
    check("t3_no_done", done_cnt - d0, 0);
    check("t3_no_ferr", ferr_cnt - f0, 0);
    check("t3_data", uart_data, 8'h0F);

    // 4: framing error then recovery
    d0 = done_cnt; f0 = ferr_cnt;
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    clks(32);
    check("t4_ferr_cnt", ferr_cnt - f0, 1);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_data_kept", uart_data, 8'h0F);
    send(8'h12, 1'b1, 1'b0, 1'b0);
    clks(4);
    check("t4_data_new", uart_data, 8'h12);
    check("t4_done_cnt", done_cnt - d0, 1);
    clks(20);

    // 5: reset during data bit 4 (0x3C bits 0..3 sent, then half of bit 4)
    d0 = done_cnt;
    uart_rxd = 1'b0;
    clks(BIT);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = (i >= 2);
      clks(BIT);
    end
    uart_rxd = 1'b1;
    clks(BIT / 2);
    sys_rst_n = 1'b0;
    clks(2);
    check("t5_rst_data", uart_data, 8'h00);
    check("t5_rst_busy", rx_busy, 0);
    check("t5_rst_done", uart_done, 0);
    check("t5_rst_ferr", frame_err, 0);
    sys_rst_n = 1'b1;
    clks(40);
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    clks(4);
    check("t5_data", uart_data, 8'h3C);
    check("t5_done_cnt", done_cnt - d0, 1);
    clks(20);

`ifdef USART_RX_PARITY_EN
    // 6: even parity, 0x07 has three ones so p must be 1
    d0 = done_cnt; p0 = perr_cnt;
    send(8'h07, 1'b1, 1'b1, 1'b1);
    clks(4);
    check("t6_good_data", uart_data, 8'h07);
    check("t6_good_done", done_cnt - d0, 1);
    check("t6_good_perr", perr_cnt - p0, 0);
    clks(20);
    d0 = done_cnt;
    send(8'h07, 1'b1, 1'b1, 1'b0);
    clks(4);
    check("t6_bad_perr", perr_cnt - p0, 1);
    check("t6_bad_done", done_cnt - d0, 0);
`else
    p0 = 0;
    check("no_parity_err", perr_cnt - p0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
